// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by a line-organised memory array.
// Serves one INCR burst of full-width beats at a time; READ_LATENCY idle
// cycles separate AR acceptance from the first R beat. A backdoor init
// port preloads the array.
// Optional feature: define AXI_RD_RANGE_CHECK_EN to answer bursts whose
// first line index lies beyond MEM_DEPTH with zero data and DECERR.
module axi_rd_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 128,
  parameter int ID_WIDTH     = 4,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  localparam int IDX_W       = $clog2(MEM_DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  init_we,
  input  logic [IDX_W-1:0]      init_addr,
  input  logic [DATA_WIDTH-1:0] init_data
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ID_WIDTH-1:0]   id_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt_q;
  logic [CNT_W-1:0]      wait_cnt_q;

  logic                  accept;
  logic                  load;
  logic [IDX_W-1:0]      load_idx;
  logic [7:0]            load_cnt;
  logic [7:0]            load_len;
  logic [ID_WIDTH-1:0]   load_id;
  logic                  load_err;

  // Byte offset within a line and bits above the array are not part of the index.
  logic [IDX_W-1:0] ar_idx;
  logic             unused_addr_bits;
  assign ar_idx           = araddr[4 +: IDX_W];
  assign unused_addr_bits = ^{araddr[3:0], araddr[ADDR_WIDTH-1:4+IDX_W]};

`ifdef AXI_RD_RANGE_CHECK_EN
  logic err_q;
  logic ar_oor;
  assign ar_oor   = (araddr >> (4 + IDX_W)) != '0;
  assign load_err = accept ? ar_oor : err_q;

  // Out-of-range flag is latched per burst and applies to every beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= ar_oor;
    end
  end
`else
  assign load_err = 1'b0;
`endif

  // Backdoor preload port; writes land in any FSM state.
  // NOTE: the array is deliberately left out of reset so it can map to RAM and
  // keep its preloaded contents across a bus reset.
  always_ff @(posedge aclk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
  end

  // Next-state logic and beat-load decisions.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load     = 1'b0;
    load_idx = idx_q;
    load_cnt = beat_cnt_q;
    load_len = len_q;
    load_id  = id_q;
    unique case (state_q)
      IDLE: begin
        if (arvalid && arready) begin
          accept = 1'b1;
          if (READ_LATENCY == 0) begin
            // Zero latency: the first beat is loaded straight from the request.
            state_d  = DATA;
            load     = 1'b1;
            load_idx = ar_idx;
            load_cnt = 8'd0;
            load_len = arlen;
            load_id  = arid;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d  = DATA;
          load     = 1'b1;
          load_cnt = 8'd0;
        end
      end
      DATA: begin
        if (rready) begin
          if (rlast) begin
            state_d = IDLE;
          end else begin
            // Index wraps naturally at MEM_DEPTH because the depth is a power of two.
            load     = 1'b1;
            load_idx = idx_q + 1'b1;
            load_cnt = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request capture and registered R-channel outputs.
  // NOTE: non-blocking assignments throughout so all registers update together.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rid        <= '0;
      rdata      <= '0;
      rresp      <= 2'b00;
      id_q       <= '0;
      idx_q      <= '0;
      len_q      <= 8'd0;
      beat_cnt_q <= 8'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // arready rises the cycle after entering IDLE, never alongside a beat.
      arready <= (state_d == IDLE);

      if (accept) begin
        id_q       <= arid;
        idx_q      <= ar_idx;
        len_q      <= arlen;
        beat_cnt_q <= 8'd0;
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      if (load) begin
        // Array read is sampled here, so a later init write cannot disturb this beat.
        rvalid     <= 1'b1;
        rid        <= load_id;
        rdata      <= load_err ? '0 : mem[load_idx];
        rresp      <= load_err ? 2'b11 : 2'b00;
        rlast      <= (load_cnt == load_len);
        idx_q      <= load_idx;
        beat_cnt_q <= load_cnt;
      end else if (state_q == DATA && rready && rlast) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: a READ_LATENCY=2 instance carries
// the table-driven bursts and corner sequences; a READ_LATENCY=0 instance
// checks back-to-back requests with arvalid held high.
module tb_axi_rd_responder;

  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int IW    = 4;
  localparam int DEPTH = 1024;
  localparam int XW    = $clog2(DEPTH);

  localparam logic [DW-1:0] PAT_A5   = {16{8'hA5}};
  localparam logic [DW-1:0] PAT_1023 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] arid = '0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          init_we = 1'b0;
  logic [XW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;

  logic [IW-1:0] arid0 = '0;
  logic [AW-1:0] araddr0 = '0;
  logic [7:0]    arlen0 = '0;
  logic          arvalid0 = 1'b0;
  logic          arready0;
  logic [IW-1:0] rid0;
  logic [DW-1:0] rdata0;
  logic [1:0]    rresp0;
  logic          rlast0;
  logic          rvalid0;
  logic          rready0 = 1'b1;

  always #5 aclk = ~aclk;

  axi_rd_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_DEPTH(DEPTH), .READ_LATENCY(2)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  axi_rd_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_DEPTH(DEPTH), .READ_LATENCY(0)
  ) u_dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid0), .araddr(araddr0), .arlen(arlen0), .arvalid(arvalid0), .arready(arready0),
    .rid(rid0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0), .rvalid(rvalid0), .rready(rready0),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Beats captured by run_burst.
  logic [DW-1:0] bd[$];
  logic          bl[$];
  logic [1:0]    br[$];
  logic [IW-1:0] bi[$];

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    int            beats;
    logic [DW-1:0] first;
    logic [DW-1:0] last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; write lands at the following posedge.
  task automatic init_line(input int idx, input logic [DW-1:0] data);
    init_we   = 1'b1;
    init_addr = XW'(idx);
    init_data = data;
    @(negedge aclk);
    init_we   = 1'b0;
  endtask

  // Returns at the negedge of the cycle following AR acceptance.
  task automatic send_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    int n = 0;
    @(negedge aclk);
    araddr  = addr;
    arlen   = len;
    arid    = id;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 20) check("ar_accept_timeout", 1'b0, 1'b1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  // Collects beats until rlast is accepted; stall drops rready every second cycle
  // and checks that a stalled beat stays put.
  task automatic run_burst(input bit stall, output int nbeats);
    logic [DW-1:0] hold_d;
    logic          hold_l;
    logic [IW-1:0] hold_i;
    bit            holding = 0;
    bit            done = 0;
    int            cyc = 0;
    nbeats = 0;
    bd.delete(); bl.delete(); br.delete(); bi.delete();
    while (!done && cyc < 600) begin
      @(negedge aclk);
      rready = stall ? (cyc % 2 == 1) : 1'b1;
      if (holding) begin
        check("hold_rdata", rdata, hold_d);
        check("hold_rlast", rlast, hold_l);
        check("hold_rid", rid, hold_i);
        holding = 0;
      end
      if (rvalid) begin
        if (rready) begin
          bd.push_back(rdata); bl.push_back(rlast); br.push_back(rresp); bi.push_back(rid);
          nbeats++;
          if (rlast) done = 1;
        end else begin
          holding = 1; hold_d = rdata; hold_l = rlast; hold_i = rid;
        end
      end
      cyc++;
    end
    if (!done) check("burst_timeout", 1'b0, 1'b1);
    @(negedge aclk);
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int n;

    vecs[0] = '{"single_50",  32'h0000_0050, 8'd0, 4'd3, 1, PAT_A5,   PAT_A5};
    vecs[1] = '{"low_bits",   32'h0000_005F, 8'd0, 4'd7, 1, PAT_A5,   PAT_A5};
    vecs[2] = '{"burst4",     32'h0000_0000, 8'd3, 4'd1, 4, 128'd0,   128'd3};
    vecs[3] = '{"burst2_mid", 32'h0000_0010, 8'd1, 4'd2, 2, 128'd1,   128'd2};
    vecs[4] = '{"wrap",       32'h0000_3FF0, 8'd1, 4'd4, 2, PAT_1023, 128'd0};

    // Reset state.
    repeat (3) @(negedge aclk);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rid", rid, '0);
    check("rst_rdata", rdata, '0);
    check("rst_rresp", rresp, 2'b00);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_arready", arready, 1'b1);

    // Preload.
    init_line(0, 128'd0);
    init_line(1, 128'd1);
    init_line(2, 128'd2);
    init_line(3, 128'd3);
    init_line(5, PAT_A5);
    init_line(1023, PAT_1023);

    // Single beat with exact latency: AR at edge T, rvalid in cycle T+3.
    send_ar(32'h50, 8'd0, 4'd3);
    check("lat_t1_rvalid", rvalid, 1'b0);
    @(negedge aclk);
    check("lat_t2_rvalid", rvalid, 1'b0);
    check("lat_t2_arready", arready, 1'b0);
    @(negedge aclk);
    check("lat_t3_rvalid", rvalid, 1'b1);
    check("lat_t3_rdata", rdata, PAT_A5);
    check("lat_t3_rid", rid, 4'd3);
    check("lat_t3_rlast", rlast, 1'b1);
    check("lat_t3_rresp", rresp, 2'b00);
    check("lat_t3_arready", arready, 1'b0);
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("lat_t4_arready", arready, 1'b1);
    check("lat_t4_rvalid", rvalid, 1'b0);

    // Table-driven bursts with rready held high.
    for (int v = 0; v < 5; v++) begin
      send_ar(vecs[v].addr, vecs[v].len, vecs[v].id);
      run_burst(1'b0, nb);
      check({vecs[v].name, "_beats"}, nb, vecs[v].beats);
      if (nb > 0) begin
        check({vecs[v].name, "_first"}, bd[0], vecs[v].first);
        check({vecs[v].name, "_last"}, bd[nb-1], vecs[v].last);
        check({vecs[v].name, "_rid"}, bi[0], vecs[v].id);
        check({vecs[v].name, "_rresp"}, br[0], 2'b00);
        check({vecs[v].name, "_rlast_end"}, bl[nb-1], 1'b1);
        if (nb > 1) check({vecs[v].name, "_rlast_early"}, bl[0], 1'b0);
      end
      check({vecs[v].name, "_arready_after"}, arready, 1'b1);
      check({vecs[v].name, "_rvalid_after"}, rvalid, 1'b0);
    end

    // Burst with back-pressure on every second cycle.
    send_ar(32'h0, 8'd3, 4'd9);
    run_burst(1'b1, nb);
    check("bp_beats", nb, 4);
    for (int i = 0; i < nb && i < 4; i++) begin
      check("bp_data", bd[i], DW'(i));
      check("bp_last", bl[i], i == 3);
    end

    // Zero latency with arvalid held high: arready and rvalid strictly alternate.
    @(negedge aclk);
    araddr0  = 32'h50;
    arlen0   = 8'd0;
    arid0    = 4'd5;
    arvalid0 = 1'b1;
    n = 0;
    while (!arready0 && n < 10) begin
      @(negedge aclk);
      n++;
    end
    check("zl_arready_seen", arready0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check("zl_rvalid", rvalid0, k % 2 == 1);
      check("zl_arready", arready0, k % 2 == 0);
      if (k % 2 == 1) begin
        check("zl_rdata", rdata0, PAT_A5);
        check("zl_rlast", rlast0, 1'b1);
        check("zl_rid", rid0, 4'd5);
      end
      @(negedge aclk);
    end
    arvalid0 = 1'b0;
    repeat (2) @(negedge aclk);

    // Out-of-range first index.
    send_ar(32'h0010_0000, 8'd1, 4'd6);
    run_burst(1'b0, nb);
    check("rng_beats", nb, 2);
    if (nb == 2) begin
      check("rng_rlast0", bl[0], 1'b0);
      check("rng_rlast1", bl[1], 1'b1);
`ifdef AXI_RD_RANGE_CHECK_EN
      check("rng_data0", bd[0], '0);
      check("rng_data1", bd[1], '0);
      check("rng_resp0", br[0], 2'b11);
      check("rng_resp1", br[1], 2'b11);
`else
      check("rng_data0", bd[0], 128'd0);
      check("rng_data1", bd[1], 128'd1);
      check("rng_resp0", br[0], 2'b00);
      check("rng_resp1", br[1], 2'b00);
`endif
    end

    // Reset in the middle of an 8-beat burst.
    send_ar(32'h0, 8'd7, 4'd8);
    rready = 1'b1;
    n = 0;
    nb = 0;
    while (nb < 2 && n < 20) begin
      @(negedge aclk);
      if (rvalid) nb++;
      n++;
    end
    check("mid_rst_beats_seen", nb, 2);
    @(negedge aclk);
    aresetn = 1'b0;
    rready  = 1'b0;
    @(negedge aclk);
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rlast", rlast, 1'b0);
    check("mid_rst_arready", arready, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_rst_release_arready", arready, 1'b1);
    check("mid_rst_release_rvalid", rvalid, 1'b0);
    send_ar(32'h50, 8'd0, 4'd9);
    run_burst(1'b0, nb);
    check("post_rst_beats", nb, 1);
    if (nb == 1) begin
      check("post_rst_data", bd[0], PAT_A5);
      check("post_rst_rid", bi[0], 4'd9);
    end

    // Init writes while a beat is presented: current beat keeps old data,
    // the next loaded beat sees the new contents.
    send_ar(32'h10, 8'd1, 4'hE);
    n = 0;
    while (!rvalid && n < 10) begin
      @(negedge aclk);
      n++;
    end
    check("init_beat_presented", rvalid, 1'b1);
    init_line(1, 128'h1111);
    check("init_same_line_held", rdata, 128'd1);
    init_line(2, 128'h2222);
    run_burst(1'b0, nb);
    check("init_beats", nb, 2);
    if (nb == 2) begin
      check("init_beat0", bd[0], 128'd1);
      check("init_beat1", bd[1], 128'h2222);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
